// File: rtl/multicycle_controller.sv
// Multi-cycle control FSM for the RISC-V core: sequences ALU, unified memory
// and register file reuse across the steps of each instruction.
module multicycle_controller #(
  parameter bit HALT_ON_ILLEGAL = 1'b1,
  parameter int INSTRET_W       = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [6:0]           op,
  input  logic                 zero,
  input  logic                 mem_ready,
  output logic                 PCWrite,
  output logic                 AdrSrc,
  output logic                 MemWrite,
  output logic                 IRWrite,
  output logic [1:0]           ResultSrc,
  output logic [1:0]           ALUSrcA,
  output logic [1:0]           ALUSrcB,
  output logic [1:0]           ALUop,
  output logic                 RegWrite_en,
  output logic                 illegal_op,
  output logic [INSTRET_W-1:0] instret,
  output logic [3:0]           state_o
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_ALUWB    = 4'd7,
    S_EXECI    = 4'd8,
    S_JAL      = 4'd9,
    S_BEQ      = 4'd10,
    S_HALT     = 4'd11
  } state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  localparam logic [INSTRET_W-1:0] ONE = INSTRET_W'(1);

  state_t                 r_state;
  logic [INSTRET_W-1:0]   r_instret;
  logic                   r_illegal;
  state_t                 w_st;
  logic                   w_pcw;
  logic                   w_irw;
  logic                   w_memw;
  logic                   w_regw;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= S_FETCH;
      r_instret <= '0;
      r_illegal <= 1'b0;
    end else begin
      unique case (r_state)
        S_FETCH:    if (mem_ready) r_state <= S_DECODE;
        S_DECODE: begin
          unique case (op)
            OP_LW, OP_SW: r_state <= S_MEMADR;
            OP_R:         r_state <= S_EXECR;
            OP_I:         r_state <= S_EXECI;
            OP_JAL:       r_state <= S_JAL;
            OP_BEQ:       r_state <= S_BEQ;
            default: begin
              r_illegal <= 1'b1;
              r_state   <= HALT_ON_ILLEGAL ? S_HALT : S_FETCH;
            end
          endcase
        end
        S_MEMADR:   r_state <= (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
        S_MEMREAD:  if (mem_ready) r_state <= S_MEMWB;
        S_MEMWB: begin
          r_state   <= S_FETCH;
          r_instret <= r_instret + ONE;
        end
        S_MEMWRITE: begin
          if (mem_ready) begin
            r_state   <= S_FETCH;
            r_instret <= r_instret + ONE;
          end
        end
        S_EXECR,
        S_EXECI,
        S_JAL:      r_state <= (r_state == S_JAL) ? S_ALUWB : S_ALUWB;
        S_ALUWB,
        S_BEQ: begin
          r_state   <= S_FETCH;
          r_instret <= r_instret + ONE;
        end
        S_HALT:     r_state <= S_HALT;
        default:    r_state <= S_FETCH;
      endcase
    end
  end

  // Selects decode as FETCH while reset is held; enables are gated below.
  assign w_st = rst_n ? r_state : S_FETCH;

  always_comb begin
    w_pcw     = 1'b0;
    w_irw     = 1'b0;
    w_memw    = 1'b0;
    w_regw    = 1'b0;
    AdrSrc    = 1'b0;
    ResultSrc = 2'b00;
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    ALUop     = 2'b00;
    unique case (w_st)
      S_FETCH: begin
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        w_irw     = mem_ready;
        w_pcw     = mem_ready;
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
      end
      S_MEMREAD:  AdrSrc = 1'b1;
      S_MEMWB: begin
        ResultSrc = 2'b01;
        w_regw    = 1'b1;
      end
      S_MEMWRITE: begin
        AdrSrc = 1'b1;
        w_memw = 1'b1;
      end
      S_EXECR: begin
        ALUSrcA = 2'b10;
        ALUop   = 2'b10;
      end
      S_ALUWB:    w_regw = 1'b1;
      S_EXECI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        ALUop   = 2'b10;
      end
      S_JAL: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b10;
        w_pcw   = 1'b1;
      end
      S_BEQ: begin
        ALUSrcA = 2'b10;
        ALUop   = 2'b01;
        w_pcw   = zero;
      end
      default: ;
    endcase
  end

  assign PCWrite     = w_pcw  & rst_n;
  assign IRWrite     = w_irw  & rst_n;
  assign MemWrite    = w_memw & rst_n;
  assign RegWrite_en = w_regw & rst_n;
  assign illegal_op  = r_illegal;
  assign instret     = r_instret;
  assign state_o     = r_state;

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: halting instance plus a
// skip-on-illegal instance with a 2-bit retire counter to exercise wrap.
module tb_multicycle_controller;

  localparam logic [6:0] OPR = 7'b0110011;
  localparam logic [6:0] OPL = 7'b0000011;
  localparam logic [6:0] OPS = 7'b0100011;
  localparam logic [6:0] OPB = 7'b1100011;
  localparam logic [6:0] OPJ = 7'b1101111;
  localparam logic [6:0] OPI = 7'b0010011;
  localparam logic [6:0] OPX = 7'b1111111;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [6:0] op = OPR;
  logic zero = 1'b0;
  logic mem_ready = 1'b1;

  logic pcw, adr, memw, irw, regw, ill;
  logic [1:0] res, sa, sb, alu;
  logic [31:0] ir;
  logic [3:0] st;

  logic pcw2, adr2, memw2, irw2, regw2, ill2;
  logic [1:0] res2, sa2, sb2, alu2;
  logic [1:0] ir2;
  logic [3:0] st2;

  int n_assert = 0;
  int n_fail = 0;

  typedef struct {
    logic [3:0]  s;
    logic [12:0] o;
    logic [31:0] ir;
    logic        il;
    logic [3:0]  s2;
    logic [1:0]  ir2;
    logic        il2;
    string       nm;
  } exp_t;

  exp_t q[$];

  always #5 clk = ~clk;

  multicycle_controller #(.HALT_ON_ILLEGAL(1'b1), .INSTRET_W(32)) u_dut (
    .clk(clk), .rst_n(rst_n), .op(op), .zero(zero), .mem_ready(mem_ready),
    .PCWrite(pcw), .AdrSrc(adr), .MemWrite(memw), .IRWrite(irw),
    .ResultSrc(res), .ALUSrcA(sa), .ALUSrcB(sb), .ALUop(alu),
    .RegWrite_en(regw), .illegal_op(ill), .instret(ir), .state_o(st)
  );

  multicycle_controller #(.HALT_ON_ILLEGAL(1'b0), .INSTRET_W(2)) u_skip (
    .clk(clk), .rst_n(rst_n), .op(op), .zero(zero), .mem_ready(mem_ready),
    .PCWrite(pcw2), .AdrSrc(adr2), .MemWrite(memw2), .IRWrite(irw2),
    .ResultSrc(res2), .ALUSrcA(sa2), .ALUSrcB(sb2), .ALUop(alu2),
    .RegWrite_en(regw2), .illegal_op(ill2), .instret(ir2), .state_o(st2)
  );

  // {PCWrite,AdrSrc,MemWrite,IRWrite,ResultSrc,ALUSrcA,ALUSrcB,ALUop,RegWrite}
  function automatic logic [12:0] eo(logic [3:0] s, logic r, logic mr,
                                     logic z);
    if (!r) return {4'b0000, 2'b10, 2'b00, 2'b10, 2'b00, 1'b0};
    case (s)
      4'd0:  return {mr, 2'b00, mr, 2'b10, 2'b00, 2'b10, 2'b00, 1'b0};
      4'd1:  return {4'b0000, 2'b00, 2'b01, 2'b01, 2'b00, 1'b0};
      4'd2:  return {4'b0000, 2'b00, 2'b10, 2'b01, 2'b00, 1'b0};
      4'd3:  return {4'b0100, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0};
      4'd4:  return {4'b0000, 2'b01, 2'b00, 2'b00, 2'b00, 1'b1};
      4'd5:  return {4'b0110, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0};
      4'd6:  return {4'b0000, 2'b00, 2'b10, 2'b00, 2'b10, 1'b0};
      4'd7:  return {4'b0000, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1};
      4'd8:  return {4'b0000, 2'b00, 2'b10, 2'b01, 2'b10, 1'b0};
      4'd9:  return {4'b1000, 2'b00, 2'b01, 2'b10, 2'b00, 1'b0};
      4'd10: return {z, 3'b000, 2'b00, 2'b10, 2'b00, 2'b01, 1'b0};
      default: return 13'd0;
    endcase
  endfunction

  task automatic step(input string nm, input logic r, input logic [6:0] o,
                      input logic mr, input logic z, input int s,
                      input int eir, input logic il, input int s2,
                      input int eir2, input logic il2);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n = r;
    op = o;
    mem_ready = mr;
    zero = z;
    e.s = 4'(s);
    e.o = eo(4'(s), r, mr, z);
    e.ir = 32'(eir);
    e.il = il;
    e.s2 = 4'(s2);
    e.ir2 = 2'(eir2);
    e.il2 = il2;
    e.nm = nm;
    q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (q.size() != 0) begin
      exp_t e;
      logic [49:0] g, x;
      logic [7:0] g2, x2;
      e = q.pop_front();
      g = {st, pcw, adr, memw, irw, res, sa, sb, alu, regw, ir, ill};
      x = {e.s, e.o, e.ir, e.il};
      n_assert++;
      if (g !== x) begin
        n_fail++;
        $display("FAIL %s: got st=%0d out=%b instret=%0d ill=%b, exp st=%0d out=%b instret=%0d ill=%b",
                 e.nm, st, g[45:33], ir, ill, e.s, e.o, e.ir, e.il);
      end
      g2 = {st2, ir2, ill2, 1'b0};
      x2 = {e.s2, e.ir2, e.il2, 1'b0};
      n_assert++;
      if (g2 !== x2) begin
        n_fail++;
        $display("FAIL %s/skip: got st=%0d instret=%0d ill=%b, exp st=%0d instret=%0d ill=%b",
                 e.nm, st2, ir2, ill2, e.s2, e.ir2, e.il2);
      end
    end
  end

  initial begin
    step("rst0",     0, OPR, 1, 0,  0, 0, 0,  0, 0, 0);
    step("rst1",     0, OPR, 1, 0,  0, 0, 0,  0, 0, 0);
    step("r_fetch",  1, OPR, 1, 0,  0, 0, 0,  0, 0, 0);
    step("r_dec",    1, OPR, 1, 0,  1, 0, 0,  1, 0, 0);
    step("r_exec",   1, OPR, 1, 0,  6, 0, 0,  6, 0, 0);
    step("r_wb",     1, OPR, 1, 0,  7, 0, 0,  7, 0, 0);
    step("lw_fetch", 1, OPL, 1, 0,  0, 1, 0,  0, 1, 0);
    step("lw_dec",   1, OPL, 1, 0,  1, 1, 0,  1, 1, 0);
    step("lw_adr",   1, OPL, 0, 0,  2, 1, 0,  2, 1, 0);
    step("lw_rd0",   1, OPL, 0, 0,  3, 1, 0,  3, 1, 0);
    step("lw_rd1",   1, OPL, 0, 0,  3, 1, 0,  3, 1, 0);
    step("lw_rd2",   1, OPL, 0, 0,  3, 1, 0,  3, 1, 0);
    step("lw_rd3",   1, OPL, 1, 0,  3, 1, 0,  3, 1, 0);
    step("lw_wb",    1, OPL, 1, 0,  4, 1, 0,  4, 1, 0);
    step("b1_fetch", 1, OPB, 1, 1,  0, 2, 0,  0, 2, 0);
    step("b1_dec",   1, OPB, 1, 1,  1, 2, 0,  1, 2, 0);
    step("b1_beq",   1, OPB, 1, 1, 10, 2, 0, 10, 2, 0);
    step("b0_fetch", 1, OPB, 1, 0,  0, 3, 0,  0, 3, 0);
    step("b0_dec",   1, OPB, 1, 0,  1, 3, 0,  1, 3, 0);
    step("b0_beq",   1, OPB, 1, 0, 10, 3, 0, 10, 3, 0);
    step("sw_fwait", 1, OPS, 0, 0,  0, 4, 0,  0, 0, 0);
    step("sw_fetch", 1, OPS, 1, 0,  0, 4, 0,  0, 0, 0);
    step("sw_dec",   1, OPS, 1, 0,  1, 4, 0,  1, 0, 0);
    step("sw_adr",   1, OPS, 1, 0,  2, 4, 0,  2, 0, 0);
    step("sw_wr",    1, OPS, 1, 0,  5, 4, 0,  5, 0, 0);
    step("sw2_fetch",1, OPS, 1, 0,  0, 5, 0,  0, 1, 0);
    step("sw2_dec",  1, OPS, 1, 0,  1, 5, 0,  1, 1, 0);
    step("sw2_adr",  1, OPS, 1, 0,  2, 5, 0,  2, 1, 0);
    step("sw2_wait", 1, OPS, 0, 0,  5, 5, 0,  5, 1, 0);
    step("sw2_rst",  0, OPS, 0, 0,  5, 5, 0,  5, 1, 0);
    step("j_fetch",  1, OPJ, 1, 0,  0, 0, 0,  0, 0, 0);
    step("j_dec",    1, OPJ, 1, 0,  1, 0, 0,  1, 0, 0);
    step("j_jal",    1, OPJ, 1, 0,  9, 0, 0,  9, 0, 0);
    step("j_wb",     1, OPJ, 1, 0,  7, 0, 0,  7, 0, 0);
    step("i_fetch",  1, OPI, 1, 0,  0, 1, 0,  0, 1, 0);
    step("i_dec",    1, OPI, 1, 0,  1, 1, 0,  1, 1, 0);
    step("i_exec",   1, OPI, 1, 0,  8, 1, 0,  8, 1, 0);
    step("i_wb",     1, OPI, 1, 0,  7, 1, 0,  7, 1, 0);
    step("x_fetch",  1, OPX, 1, 0,  0, 2, 0,  0, 2, 0);
    step("x_dec",    1, OPX, 1, 0,  1, 2, 0,  1, 2, 0);
    for (int k = 0; k < 10; k++)
      step("halt",   1, OPX, 1, 0, 11, 2, 1, k % 2, 2, 1);
    step("halt_rst", 0, OPX, 1, 0, 11, 2, 1,  0, 2, 1);
    step("post_rst", 1, OPX, 1, 0,  0, 0, 0,  0, 0, 0);
    for (int i = 0; i < 10 && q.size() != 0; i++) @(negedge clk);
    #1;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
